quantum_scheduler: RTL and testbench

- Round-robin time-slice scheduler for the core's user processes.
- Counts retired user instructions against a quantum and keeps a per-process saved-PC table.
- Sequences the context switch: redirect PC to the OS switch routine, save handshake, select next ready process, restore handshake, reload PC.
- Sits between the PC register/fetch stage and the OS context store.

---
 rtl/quantum_scheduler_if.sv | 35 +++
 rtl/quantum_scheduler.sv | 180 ++++++++++++++++++
 tb/tb_quantum_scheduler.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/quantum_scheduler_if.sv
// Bundles the scheduler's core-side and context-store-side signals.
// master: the core / OS context store driving the scheduler.
// slave : the scheduler itself.
interface quantum_scheduler_if #(
    parameter int unsigned NUM_PROC = 4,
    parameter int unsigned PID_W    = 2
);
    logic                instr_retire;
    logic                sys_yield;
    logic [31:0]         pc_curr;
    logic [NUM_PROC-1:0] ready_mask;
    logic                save_ack;
    logic                restore_ack;
    logic [31:0]         pc_new;
    logic                pc_load;
    logic                enable_so;
    logic                save_req;
    logic                restore_req;
    logic [PID_W-1:0]    cur_pid;
    logic [PID_W-1:0]    next_pid;
    logic [7:0]          slice_cnt;
    logic                sched_fault;

    modport master (
        output instr_retire, sys_yield, pc_curr, ready_mask, save_ack, restore_ack,
        input  pc_new, pc_load, enable_so, save_req, restore_req,
               cur_pid, next_pid, slice_cnt, sched_fault
    );

    modport slave (
        input  instr_retire, sys_yield, pc_curr, ready_mask, save_ack, restore_ack,
        output pc_new, pc_load, enable_so, save_req, restore_req,
               cur_pid, next_pid, slice_cnt, sched_fault
    );
endinterface

// File: rtl/quantum_scheduler.sv
// Round-robin time-slice scheduler.
// Counts retired user instructions against QUANTUM, keeps a saved-PC table per
// process and sequences the context switch through the OS switch routine:
// RUN -> SAVE -> SELECT -> RESTORE -> RUN.
// Optional ack watchdog: define QUANTUM_SCHEDULER_WATCHDOG_EN.
module quantum_scheduler #(
    parameter int unsigned NUM_PROC    = 4,
    parameter int unsigned PID_W       = 2,
    parameter int unsigned QUANTUM     = 20,
    parameter logic [31:0] SO_PC       = 32'd3,
    parameter logic [31:0] PROC_BASE   = 32'h100,
    parameter logic [31:0] PROC_STRIDE = 32'h100,
    parameter int unsigned ACK_TIMEOUT = 64
) (
    input  logic               clk,
    input  logic               reset,
    quantum_scheduler_if.slave bus
);
    typedef enum logic [1:0] {
        RUN     = 2'd0,
        SAVE    = 2'd1,
        SELECT  = 2'd2,
        RESTORE = 2'd3
    } state_t;

    localparam logic [7:0] SliceLast = 8'(QUANTUM - 1);

    state_t           r_state;
    logic [31:0]      r_pcTable [NUM_PROC];
    logic [31:0]      r_pcNew;
    logic             r_pcLoad;
    logic             r_enableSo;
    logic             r_saveReq;
    logic             r_restoreReq;
    logic [PID_W-1:0] r_curPid;
    logic [PID_W-1:0] r_nextPid;
    logic [7:0]       r_sliceCnt;

    logic             w_trigger;
    logic [PID_W-1:0] w_pick;
    logic             w_pickValid;

`ifdef QUANTUM_SCHEDULER_WATCHDOG_EN
    localparam int unsigned WdW = $clog2(ACK_TIMEOUT + 1);
    logic [WdW-1:0] r_wdCnt;
    logic           r_schedFault;
    logic           w_wdExpired;

    // The watchdog fires on the cycle the pending request reaches its age limit
    assign w_wdExpired = (r_saveReq || r_restoreReq) && (r_wdCnt == WdW'(ACK_TIMEOUT - 1));
`endif

    // A quantum expiry and a yield in the same cycle are one switch request
    assign w_trigger = (bus.instr_retire && (r_sliceCnt == SliceLast)) || bus.sys_yield;

    // Round-robin pick: scan cur+1, cur+2, ... wrapping, ending on cur itself
    always_comb begin
        logic [PID_W-1:0] idx;
        idx         = '0;
        w_pick      = r_curPid;
        w_pickValid = 1'b0;
        for (int k = 1; k <= int'(NUM_PROC); k++) begin
            idx = r_curPid + PID_W'(k);
            if (!w_pickValid && bus.ready_mask[idx]) begin
                w_pick      = idx;
                w_pickValid = 1'b1;
            end
        end
    end

    // Switch sequencer with all outputs and the saved-PC table registered
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= RUN;
            r_pcNew      <= '0;
            r_pcLoad     <= 1'b0;
            r_enableSo   <= 1'b0;
            r_saveReq    <= 1'b0;
            r_restoreReq <= 1'b0;
            r_curPid     <= '0;
            r_nextPid    <= '0;
            r_sliceCnt   <= '0;
            for (int i = 0; i < int'(NUM_PROC); i++) begin
                r_pcTable[i] <= PROC_BASE + (32'(i) * PROC_STRIDE);
            end
`ifdef QUANTUM_SCHEDULER_WATCHDOG_EN
            r_wdCnt      <= '0;
            r_schedFault <= 1'b0;
`endif
        end else begin
            r_pcLoad <= 1'b0;

`ifdef QUANTUM_SCHEDULER_WATCHDOG_EN
            if (r_saveReq || r_restoreReq) begin
                r_wdCnt <= w_wdExpired ? '0 : r_wdCnt + WdW'(1);
            end else begin
                r_wdCnt <= '0;
            end
`endif

            case (r_state)
                RUN: begin
                    if (w_trigger) begin
                        r_pcTable[r_curPid] <= bus.pc_curr;
                        r_pcNew             <= SO_PC;
                        r_pcLoad            <= 1'b1;
                        r_enableSo          <= 1'b1;
                        r_saveReq           <= 1'b1;
                        r_state             <= SAVE;
                    end else if (bus.instr_retire) begin
                        r_sliceCnt <= r_sliceCnt + 8'd1;
                    end
                end

                SAVE: begin
                    if (r_saveReq && bus.save_ack) begin
                        r_saveReq <= 1'b0;
                        r_state   <= SELECT;
                    end
`ifdef QUANTUM_SCHEDULER_WATCHDOG_EN
                    else if (w_wdExpired) begin
                        r_schedFault <= 1'b1;
                        r_saveReq    <= 1'b0;
                        r_pcNew      <= SO_PC;
                        r_pcLoad     <= 1'b1;
                        r_enableSo   <= 1'b1;
                        r_state      <= SELECT;
                    end
`endif
                end

                SELECT: begin
                    if (w_pickValid) begin
                        r_nextPid    <= w_pick;
                        r_restoreReq <= 1'b1;
                        r_state      <= RESTORE;
                    end
                end

                RESTORE: begin
                    if (r_restoreReq && bus.restore_ack) begin
                        r_pcNew      <= r_pcTable[r_nextPid];
                        r_pcLoad     <= 1'b1;
                        r_curPid     <= r_nextPid;
                        r_sliceCnt   <= '0;
                        r_enableSo   <= 1'b0;
                        r_restoreReq <= 1'b0;
                        r_state      <= RUN;
                    end
`ifdef QUANTUM_SCHEDULER_WATCHDOG_EN
                    else if (w_wdExpired) begin
                        r_schedFault <= 1'b1;
                        r_restoreReq <= 1'b0;
                        r_pcNew      <= SO_PC;
                        r_pcLoad     <= 1'b1;
                        r_enableSo   <= 1'b1;
                        r_state      <= SELECT;
                    end
`endif
                end

                default: r_state <= RUN;
            endcase
        end
    end

    assign bus.pc_new      = r_pcNew;
    assign bus.pc_load     = r_pcLoad;
    assign bus.enable_so   = r_enableSo;
    assign bus.save_req    = r_saveReq;
    assign bus.restore_req = r_restoreReq;
    assign bus.cur_pid     = r_curPid;
    assign bus.next_pid    = r_nextPid;
    assign bus.slice_cnt   = r_sliceCnt;
`ifdef QUANTUM_SCHEDULER_WATCHDOG_EN
    assign bus.sched_fault = r_schedFault;
`else
    assign bus.sched_fault = 1'b0;
`endif
endmodule

// File: tb/tb_quantum_scheduler.sv
// Self-checking bench for quantum_scheduler: directed switch scenarios plus
// randomized slices, checked against a transaction-level model of the
// saved-PC table, the running process and the slice count.
module tb_quantum_scheduler;
   localparam int NUM_PROC = 4;
   localparam int QUANTUM = 20;
   localparam logic [31:0] SO_PC = 32'd3;

   logic clk;
   logic reset;

   quantum_scheduler_if #(.NUM_PROC(NUM_PROC), .PID_W(2)) bus ();

   quantum_scheduler dut (
      .clk(clk),
      .reset(reset),
      .bus(bus.slave)
   );

   int total = 0;
   int bad = 0;

   logic [31:0] pcTable [NUM_PROC];
   int mCur;
   int mNext;
   int mSlice;
   bit mFault;

   // Free-running clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      total++;
      assert (observed === expected)
      else begin
         bad++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input bit retire, input bit yieldReq, input logic [31:0] pc,
                                input bit sAck, input bit rAck);
      bus.instr_retire = retire;
      bus.sys_yield = yieldReq;
      bus.pc_curr = pc;
      bus.save_ack = sAck;
      bus.restore_ack = rAck;
   endtask

   task automatic modelReset();
      for (int i = 0; i < NUM_PROC; i++) pcTable[i] = 32'h100 * 32'(i + 1);
      mCur = 0;
      mNext = 0;
      mSlice = 0;
      mFault = 1'b0;
   endtask

   function automatic int pickNext(input int cur, input logic [3:0] mask);
      for (int k = 1; k <= NUM_PROC; k++) begin
         if (mask[(cur + k) % NUM_PROC]) return (cur + k) % NUM_PROC;
      end
      return -1;
   endfunction

   task automatic checkResetOutputs(input string tag);
      checkOutput({tag, ".pc_new"}, bus.pc_new, 32'd0);
      checkOutput({tag, ".pc_load"}, 32'(bus.pc_load), 32'd0);
      checkOutput({tag, ".enable_so"}, 32'(bus.enable_so), 32'd0);
      checkOutput({tag, ".save_req"}, 32'(bus.save_req), 32'd0);
      checkOutput({tag, ".restore_req"}, 32'(bus.restore_req), 32'd0);
      checkOutput({tag, ".cur_pid"}, 32'(bus.cur_pid), 32'd0);
      checkOutput({tag, ".next_pid"}, 32'(bus.next_pid), 32'd0);
      checkOutput({tag, ".slice_cnt"}, 32'(bus.slice_cnt), 32'd0);
      checkOutput({tag, ".sched_fault"}, 32'(bus.sched_fault), 32'd0);
   endtask

   // Run user code until a switch triggers. yieldAt<0: quantum only.
   task automatic runSlice(input int yieldAt, input bit randGaps, input bit retireOnYield,
                           input logic [31:0] yieldPc);
      bit done = 1'b0;
      int guard = 0;
      while (!done) begin
         bit retire;
         bit yieldNow;
         bit trig;
         logic [31:0] pc;
         retire = randGaps ? 1'($urandom_range(0, 1)) : 1'b1;
         pc = $urandom;
         yieldNow = (yieldAt >= 0) && (mSlice == yieldAt);
         if (yieldNow) begin
            retire = retireOnYield;
            if (yieldPc != 32'd0) pc = yieldPc;
         end
         applyStimulus(retire, yieldNow, pc, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
         bus.ready_mask = 4'($urandom_range(0, 15));
         trig = yieldNow || (retire && mSlice == QUANTUM - 1);
         if (trig) pcTable[mCur] = pc;
         else if (retire) mSlice++;
         @(negedge clk);
         if (trig) begin
            checkOutput("so_pc_load", 32'(bus.pc_load), 32'd1);
            checkOutput("so_pc_new", bus.pc_new, SO_PC);
            checkOutput("so_enable", 32'(bus.enable_so), 32'd1);
            checkOutput("so_save_req", 32'(bus.save_req), 32'd1);
            done = 1'b1;
         end else begin
            checkOutput("run_slice_cnt", 32'(bus.slice_cnt), 32'(mSlice));
            checkOutput("run_enable_so", 32'(bus.enable_so), 32'd0);
            checkOutput("run_pc_load", 32'(bus.pc_load), 32'd0);
         end
         guard++;
         if (!done && guard > 2000) begin
            checkOutput("run_timeout", 32'd1, 32'd0);
            done = 1'b1;
         end
      end
      applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
   endtask

   // Hold off save_ack for some cycles, then acknowledge once
   task automatic doSave(input int delay);
      for (int i = 0; i < delay; i++) begin
         applyStimulus(1'($urandom_range(0, 1)), 1'b0, $urandom, 1'b0, 1'b0);
         bus.ready_mask = 4'($urandom_range(0, 15));
         @(negedge clk);
         checkOutput("save_req_held", 32'(bus.save_req), 32'd1);
         checkOutput("save_enable_so", 32'(bus.enable_so), 32'd1);
         checkOutput("save_slice_frozen", 32'(bus.slice_cnt), 32'(mSlice));
         checkOutput("save_pc_load", 32'(bus.pc_load), 32'd0);
      end
      applyStimulus(1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
      @(negedge clk);
      checkOutput("save_req_drop", 32'(bus.save_req), 32'd0);
      checkOutput("select_enable_so", 32'(bus.enable_so), 32'd1);
      checkOutput("select_no_restore", 32'(bus.restore_req), 32'd0);
      bus.save_ack = 1'b0;
   endtask

   // Present the mask in SELECT, optionally after some cycles with nobody ready
   task automatic doSelect(input logic [3:0] mask, input int zeroCycles);
      int expPid;
      if (zeroCycles > 0) begin
         bus.ready_mask = 4'd0;
         for (int i = 0; i < zeroCycles; i++) begin
            @(negedge clk);
            checkOutput("idle_restore_req", 32'(bus.restore_req), 32'd0);
            checkOutput("idle_enable_so", 32'(bus.enable_so), 32'd1);
         end
      end
      bus.ready_mask = mask;
      expPid = pickNext(mCur, mask);
      @(negedge clk);
      checkOutput("pick_restore_req", 32'(bus.restore_req), 32'd1);
      checkOutput("pick_next_pid", 32'(bus.next_pid), 32'(expPid));
      mNext = expPid;
   endtask

   // Hold off restore_ack for some cycles, then acknowledge and check the reload
   task automatic doRestore(input int delay);
      for (int i = 0; i < delay; i++) begin
         applyStimulus(1'($urandom_range(0, 1)), 1'b0, $urandom, 1'b0, 1'b0);
         bus.ready_mask = 4'($urandom_range(0, 15));
         @(negedge clk);
         checkOutput("restore_req_held", 32'(bus.restore_req), 32'd1);
         checkOutput("restore_pc_load", 32'(bus.pc_load), 32'd0);
      end
      applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 1'b1);
      @(negedge clk);
      mCur = mNext;
      mSlice = 0;
      checkOutput("user_pc_load", 32'(bus.pc_load), 32'd1);
      checkOutput("user_pc_new", bus.pc_new, pcTable[mCur]);
      checkOutput("user_cur_pid", 32'(bus.cur_pid), 32'(mCur));
      checkOutput("user_slice_cnt", 32'(bus.slice_cnt), 32'd0);
      checkOutput("user_enable_so", 32'(bus.enable_so), 32'd0);
      checkOutput("user_restore_req", 32'(bus.restore_req), 32'd0);
      checkOutput("user_sched_fault", 32'(bus.sched_fault), 32'(mFault));
      bus.restore_ack = 1'b0;
      @(negedge clk);
      checkOutput("user_pc_load_pulse", 32'(bus.pc_load), 32'd0);
   endtask

   // Directed scenarios followed by randomized switches
   initial begin
      reset = 1'b1;
      applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
      bus.ready_mask = 4'b1111;
      modelReset();
      @(negedge clk);
      @(negedge clk);
      checkResetOutputs("reset");
      reset = 1'b0;

      $display("[TB] first quantum switch 0 -> 1");
      runSlice(-1, 1'b0, 1'b0, 32'd0);
      doSave(3);
      doSelect(4'b1111, 0);
      doRestore(2);

      $display("[TB] yield in pid 1 at slice 5");
      runSlice(5, 1'b0, 1'b0, 32'h248);
      doSave(1);
      doSelect(4'b1111, 0);
      doRestore(1);
      runSlice(-1, 1'b1, 1'b0, 32'd0);
      doSave(2);
      doSelect(4'b0010, 0);
      doRestore(0);

      $display("[TB] self reselect and wrap");
      runSlice(-1, 1'b1, 1'b0, 32'd0);
      doSave(0);
      doSelect(4'b1000, 0);
      doRestore(1);
      runSlice(-1, 1'b1, 1'b0, 32'd0);
      doSave(1);
      doSelect(4'b1000, 0);
      doRestore(0);
      runSlice(-1, 1'b1, 1'b0, 32'd0);
      doSave(2);
      doSelect(4'b0100, 0);
      doRestore(1);

      $display("[TB] empty ready mask in SELECT");
      runSlice(-1, 1'b1, 1'b0, 32'd0);
      doSave(1);
      doSelect(4'b0010, 10);
      doRestore(1);

      $display("[TB] yield coincident with last retire");
      runSlice(QUANTUM - 1, 1'b0, 1'b1, 32'd0);
      doSave(3);
      doSelect(4'b1111, 0);
      doRestore(0);

      $display("[TB] randomized switches");
      for (int n = 0; n < 8; n++) begin
         int yAt;
         yAt = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, QUANTUM - 1)) : -1;
         runSlice(yAt, 1'b1, 1'b0, 32'd0);
         doSave(int'($urandom_range(0, 5)));
         doSelect(4'($urandom_range(1, 15)), ($urandom_range(0, 3) == 0) ? 3 : 0);
         doRestore(int'($urandom_range(0, 5)));
      end

      $display("[TB] reset during RESTORE");
      runSlice(-1, 1'b1, 1'b0, 32'd0);
      doSave(0);
      doSelect(4'b1111, 0);
      @(negedge clk);
      checkOutput("pre_reset_restore_req", 32'(bus.restore_req), 32'd1);
      #2 reset = 1'b1;
      #1 checkResetOutputs("async_reset");
      @(negedge clk);
      reset = 1'b0;
      modelReset();
      bus.ready_mask = 4'b1111;
      runSlice(-1, 1'b0, 1'b0, 32'd0);
      doSave(1);
      doSelect(4'b1111, 0);
      doRestore(1);

`ifdef QUANTUM_SCHEDULER_WATCHDOG_EN
      $display("[TB] save ack withheld");
      runSlice(-1, 1'b1, 1'b0, 32'd0);
      for (int i = 1; i < 64; i++) begin
         @(negedge clk);
         checkOutput("wd_wait_save_req", 32'(bus.save_req), 32'd1);
         checkOutput("wd_wait_fault", 32'(bus.sched_fault), 32'd0);
      end
      @(negedge clk);
      mFault = 1'b1;
      checkOutput("wd_fault", 32'(bus.sched_fault), 32'd1);
      checkOutput("wd_save_req", 32'(bus.save_req), 32'd0);
      checkOutput("wd_pc_load", 32'(bus.pc_load), 32'd1);
      checkOutput("wd_pc_new", bus.pc_new, SO_PC);
      checkOutput("wd_enable_so", 32'(bus.enable_so), 32'd1);
      doSelect(4'b1111, 0);
      doRestore(0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
